// File: rtl/nibble_serial_add_seq.sv
// Issues a WIDTH-bit add as NIBBLES slices on one external 4-bit adder, chaining carry between slices.
// Result is valid at edge T+NIBBLES+1 after accept T; held stable with out_valid high until out_ready.
module nibble_serial_add_seq #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       fa_a,
  output logic [3:0]       fa_b,
  output logic             fa_cin,
  input  logic [3:0]       fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic [NIBBLES-1:0][3:0] a_reg, b_reg, sum_reg;
  logic                    last_nib;
  logic                    accept;

  assign last_nib = (idx == IW'(NIBBLES - 1));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    fa_a      = 4'h0;
    fa_b      = 4'h0;
    fa_cin    = 1'b0;
    case (state)
      IDLE: begin
        // in_ready is combinational so it drops the moment rst rises
        in_ready = ~rst;
        if (in_valid && !rst) state_nxt = RUN;
      end
      RUN: begin
        fa_a   = a_reg[idx];
        fa_b   = b_reg[idx];
        fa_cin = carry;
        if (last_nib) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = sum_reg;
        out_cout  = carry;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            carry   <= in_cin;
            idx     <= '0;
            sum_reg <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= fa_sum;
          carry        <= fa_cout;
          // idx parks on the top slice rather than wrapping
          if (!last_nib) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed and random checks of nibble_serial_add_seq driving a behavioural 4-bit adder.
module tb_nibble_serial_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_cin;
  logic [3:0]  fa_a, fa_b, fa_sum;
  logic        fa_cin, fa_cout;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic [4:0]  fa_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // fa_4bit stand-in: combinational 4-bit full adder
  assign fa_res  = {1'b0, fa_a} + {1'b0, fa_b} + {4'b0, fa_cin};
  assign fa_sum  = fa_res[3:0];
  assign fa_cout = fa_res[4];

  nibble_serial_add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, latency, optional DONE stall with in_valid noise, handshake.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int stall, input logic noise,
                        input logic [15:0] exp_sum, input logic exp_cout);
    int e;
    @(negedge clk);
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = ~cin;
    chk({tag, " fa_a nib0"}, fa_a, a[3:0]);
    chk({tag, " fa_b nib0"}, fa_b, b[3:0]);
    chk({tag, " fa_cin nib0"}, fa_cin, cin);
    e = 0;
    while (!out_valid && e < 20) begin
      @(posedge clk);
      #1;
      e++;
    end
    // valid is present after NIBBLES edges, so the consumer can take it at edge T+NIBBLES+1
    chk({tag, " latency"}, e, 4);
    for (int s = 0; s < stall; s++) begin
      if (noise) begin
        in_valid = 1'b1; in_a = 16'h5555; in_b = 16'h3333; in_cin = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({tag, " stall valid"}, out_valid, 1);
      chk({tag, " stall sum"}, out_sum, exp_sum);
      chk({tag, " stall in_ready"}, in_ready, 0);
      chk({tag, " stall fa_a"}, fa_a, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, " sum"}, out_sum, exp_sum);
    chk({tag, " cout"}, out_cout, exp_cout);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " valid drop"}, out_valid, 0);
    chk({tag, " back to idle"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] ref_res;
    logic [15:0] ra, rb;
    logic        rc;
    logic        seen;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #2;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset out_cout", out_cout, 0);
    chk("reset fa_a", fa_a, 0);
    chk("reset fa_b", fa_b, 0);
    chk("reset fa_cin", fa_cin, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle in_ready", in_ready, 1);
    chk("idle fa_a", fa_a, 0);

    run_op("add 9+2",       16'h0009, 16'h0002, 1'b0, 0, 1'b0, 16'h000B, 1'b0);
    run_op("ripple ffff+1", 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0000, 1'b1);
    run_op("8000+8000+1",   16'h8000, 16'h8000, 1'b1, 0, 1'b0, 16'h0001, 1'b1);
    run_op("1234+0fff",     16'h1234, 16'h0FFF, 1'b0, 3, 1'b1, 16'h2233, 1'b0);

    // Reset while idx==2: result must be discarded
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'h0FFF; in_b = 16'h0FFF; in_cin = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst in_ready", in_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst fa_a", fa_a, 0);
    chk("midrst out_sum", out_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    chk("post rst no valid", seen, 0);
    run_op("00ff+1", 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, 16'h0100, 1'b0);

    for (int n = 0; n < 50; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ref_res = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      run_op("random", ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom),
             ref_res[15:0], ref_res[16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
